// File: rtl/i2c_packet_sequencer.sv
// i2c_packet_sequencer
// Sequences one I2C write packet through an external byte master. The packet
// is START + address byte, NUM_BYTES payload bytes, then STOP. Any NACK or
// abort still finishes with a STOP so the bus is always released.
// Optional build macro: I2C_SEQ_RETRY_EN enables re-sending a packet that
// failed on a NACK, up to MAX_RETRY times, using the same snapshot.
module i2c_packet_sequencer #(
    parameter int         NUM_BYTES  = 5,
    parameter logic [6:0] SLAVE_ADDR = 7'h55,
    parameter int         MAX_RETRY  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   send_trigger,
    input  logic                   abort,
    input  logic [8*NUM_BYTES-1:0] payload,
    input  logic                   ready,
    input  logic                   nack,
    output logic                   start,
    output logic                   stop,
    output logic                   i2c_en,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);

    localparam int             IW         = $clog2(NUM_BYTES + 1);
    localparam logic [IW-1:0]  LAST_COUNT = IW'(NUM_BYTES);
    localparam logic [7:0]     ADDR_BYTE  = {SLAVE_ADDR, 1'b0};

    typedef enum logic [2:0] {
        IDLE,
        START_REQ,
        START_WAIT,
        DATA_REQ,
        DATA_WAIT,
        STOP_REQ,
        STOP_WAIT,
        DONE
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] index_reg, index_next;
    logic          fail_reg, fail_next;
    logic [7:0]    tx_data_reg, tx_data_next;
    logic [7:0]    snap_reg [NUM_BYTES];
    logic          snap_load;
    logic [7:0]    cur_byte;

`ifdef I2C_SEQ_RETRY_EN
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
    logic [2:0]    retry_reg, retry_next;
    // Distinguishes a NACK failure (retryable) from an abort (never retried).
    logic          nack_fail_reg, nack_fail_next;
`endif

    // Payload snapshot, one register per byte, captured when a packet is accepted.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_snap
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                snap_reg[gi] <= 8'h00;
            end else if (snap_load) begin
                snap_reg[gi] <= payload[8*gi +: 8];
            end
        end
    end

    // Select the snapshot byte addressed by the current index (0 once past the end).
    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < NUM_BYTES; k++) begin
            if (index_reg == IW'(k)) begin
                cur_byte = snap_reg[k];
            end
        end
    end

    // Next-state and datapath-next logic for the packet sequencer.
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        fail_next    = fail_reg;
        tx_data_next = tx_data_reg;
        snap_load    = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        retry_next     = retry_reg;
        nack_fail_next = nack_fail_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (send_trigger) begin
                    snap_load    = 1'b1;
                    index_next   = '0;
                    fail_next    = 1'b0;
                    tx_data_next = ADDR_BYTE;
                    state_next   = START_REQ;
`ifdef I2C_SEQ_RETRY_EN
                    retry_next     = 3'd0;
                    nack_fail_next = 1'b0;
`endif
                end
            end
            START_REQ, DATA_REQ: begin
                if (abort) begin
                    fail_next  = 1'b1;
                    state_next = STOP_REQ;
                end else if (!ready) begin
                    // Byte master accepted the command.
                    if (state_reg == DATA_REQ) begin
                        index_next = index_reg + IW'(1);
                        state_next = DATA_WAIT;
                    end else begin
                        state_next = START_WAIT;
                    end
                end
            end
            START_WAIT, DATA_WAIT: begin
                if (abort) begin
                    fail_next  = 1'b1;
                    state_next = STOP_REQ;
                end else if (ready) begin
                    if (nack) begin
                        fail_next  = 1'b1;
                        state_next = STOP_REQ;
`ifdef I2C_SEQ_RETRY_EN
                        nack_fail_next = 1'b1;
`endif
                    end else if (index_reg < LAST_COUNT) begin
                        tx_data_next = cur_byte;
                        state_next   = DATA_REQ;
                    end else begin
                        state_next = STOP_REQ;
                    end
                end
            end
            STOP_REQ: begin
                if (!ready) begin
                    state_next = STOP_WAIT;
                end
            end
            STOP_WAIT: begin
                if (ready) begin
                    state_next = DONE;
`ifdef I2C_SEQ_RETRY_EN
                    if (fail_reg && nack_fail_reg && (retry_reg < RETRY_LIMIT)) begin
                        retry_next     = retry_reg + 3'd1;
                        fail_next      = 1'b0;
                        nack_fail_next = 1'b0;
                        index_next     = '0;
                        tx_data_next   = ADDR_BYTE;
                        state_next     = START_REQ;
                    end
`endif
                end
            end
            DONE: begin
                // Level trigger: wait for it to drop so one request sends one packet.
                if (!send_trigger) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            fail_reg    <= 1'b0;
            tx_data_reg <= 8'h00;
`ifdef I2C_SEQ_RETRY_EN
            retry_reg     <= 3'd0;
            nack_fail_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            fail_reg    <= fail_next;
            tx_data_reg <= tx_data_next;
`ifdef I2C_SEQ_RETRY_EN
            retry_reg     <= retry_next;
            nack_fail_reg <= nack_fail_next;
`endif
        end
    end

    // Command strobes and status decoded directly from the state.
    always_comb begin
        start   = (state_reg == START_REQ);
        stop    = (state_reg == STOP_REQ);
        i2c_en  = (state_reg == START_REQ) || (state_reg == DATA_REQ) || (state_reg == STOP_REQ);
        busy    = (state_reg != IDLE) && (state_reg != DONE);
        done    = (state_reg == DONE);
        error   = (state_reg == DONE) && fail_reg;
        tx_data = tx_data_reg;
    end

endmodule

// File: tb/tb_i2c_packet_sequencer.sv
// Testbench for i2c_packet_sequencer: a byte-master model drives ready/nack/abort
// and logs each accepted command; a packet-level model predicts the command list.
module tb_i2c_packet_sequencer;

    localparam int         NB = 5;
    localparam logic [6:0] SA = 7'h55;
    localparam int         MR = 2;
`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          send_trigger = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b1;
    logic          nack = 1'b0;
    logic [8*NB-1:0] payload = '0;
    logic          start, stop, i2c_en, busy, done, error;
    logic [7:0]    tx_data;

    int errors = 0;
    int checks = 0;

    // Expected commands: {start, stop, byte}
    logic [9:0] exp_q[$];
    int         plan_nack[8];
    int         abort_slot = -1;
    bit         sb_en = 1'b1;

    int         bfm_att = -1;
    int         bfm_slot = 0;
    int         bfm_cnt = 0;
    bit         pend_nack = 1'b0;
    bit         pend_abort = 1'b0;
    int         cap_starts = 0;
    int         cap_stops = 0;
    logic [7:0] cap_log[$];

    always #5 clk = ~clk;

    i2c_packet_sequencer #(
        .NUM_BYTES (NB),
        .SLAVE_ADDR(SA),
        .MAX_RETRY (MR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .send_trigger(send_trigger),
        .abort       (abort),
        .payload     (payload),
        .ready       (ready),
        .nack        (nack),
        .start       (start),
        .stop        (stop),
        .i2c_en      (i2c_en),
        .tx_data     (tx_data),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Packet-level model: slot 0 is the address byte, slot k is payload byte k-1.
    function automatic bit model(input logic [8*NB-1:0] pl);
        bit fail;
        bit aborted;
        int a;
        a = 0;
        while (1) begin
            fail = 1'b0;
            aborted = 1'b0;
            for (int slot = 0; slot <= NB; slot++) begin
                if (slot == 0) exp_q.push_back({2'b10, SA, 1'b0});
                else           exp_q.push_back({2'b00, pl[8*(slot-1) +: 8]});
                if (a == 0 && abort_slot == slot) begin
                    fail = 1'b1;
                    aborted = 1'b1;
                    break;
                end
                if (plan_nack[a] == slot) begin
                    fail = 1'b1;
                    break;
                end
            end
            exp_q.push_back({2'b01, 8'h00});
            if (fail && !aborted && RETRY_EN && a < MR) a++;
            else return fail;
        end
        return 1'b1;
    endfunction

    // Byte-master model with scoreboard of accepted commands.
    always @(negedge clk) begin
        logic [9:0] e;
        if (!reset) begin
            ready = 1'b1;
            nack = 1'b0;
            abort = 1'b0;
            bfm_cnt = 0;
            bfm_att = -1;
            pend_nack = 1'b0;
            pend_abort = 1'b0;
        end else if (!ready) begin
            if (bfm_cnt == 0) begin
                ready = 1'b1;
                nack = pend_nack;
                abort = pend_abort;
            end else begin
                bfm_cnt--;
            end
        end else begin
            abort = 1'b0;
            if (done) bfm_att = -1;
            if (i2c_en) begin
                pend_nack = 1'b0;
                pend_abort = 1'b0;
                if (start) begin
                    bfm_att++;
                    bfm_slot = 0;
                    cap_starts++;
                end else if (stop) begin
                    cap_stops++;
                end else begin
                    bfm_slot++;
                end
                if (!stop && bfm_att >= 0 && bfm_att < 8) begin
                    pend_abort = (bfm_att == 0) && (abort_slot == bfm_slot);
                    pend_nack = (plan_nack[bfm_att] == bfm_slot) && !pend_abort;
                end
                if (!stop) cap_log.push_back(tx_data);
                if (sb_en) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL txn_extra: got start=%0b stop=%0b data=%02h, required no command",
                                 start, stop, tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        $display("txn t=%0t start=%0b stop=%0b data=%02h | exp start=%0b stop=%0b data=%02h",
                                 $time, start, stop, tx_data, e[9], e[8], e[7:0]);
                        if (start !== e[9] || stop !== e[8] || (!stop && tx_data !== e[7:0])) begin
                            errors++;
                            $display("FAIL txn_cmd: got start=%0b stop=%0b data=%02h, required start=%0b stop=%0b data=%02h",
                                     start, stop, tx_data, e[9], e[8], e[7:0]);
                        end
                    end
                end else begin
                    $display("txn t=%0t start=%0b stop=%0b data=%02h (unscored)", $time, start, stop, tx_data);
                end
                nack = 1'b0;
                ready = 1'b0;
                bfm_cnt = $urandom_range(0, 3);
            end
        end
    end

    // Per-cycle output consistency.
    always @(negedge clk) begin
        if (reset) begin
            checks++;
            if (((start || stop) && !i2c_en) || (start && stop) || (done && (busy || i2c_en)) || (error && !done)) begin
                errors++;
                $display("FAIL cycle_outputs: got start=%0b stop=%0b i2c_en=%0b busy=%0b done=%0b error=%0b",
                         start, stop, i2c_en, busy, done, error);
            end
        end
    end

    task automatic clear_plan();
        for (int i = 0; i < 8; i++) plan_nack[i] = -1;
        abort_slot = -1;
    endtask

    task automatic run_packet(input logic [8*NB-1:0] pl, input bit scramble, input bit hold, input string tag);
        bit exp_err;
        int n0;
        int cyc;
        exp_q.delete();
        exp_err = model(pl);
        @(negedge clk);
        payload = pl;
        send_trigger = 1'b1;
        @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        if (scramble) payload = '1;
        cyc = 0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, error, exp_err);
        check({tag, "_busy_in_done"}, busy, 0);
        check({tag, "_all_cmds_seen"}, exp_q.size(), 0);
        if (hold) begin
            n0 = cap_starts;
            repeat (6) @(negedge clk);
            check({tag, "_done_held"}, done, 1);
            check({tag, "_no_restart"}, cap_starts - n0, 0);
        end
        send_trigger = 1'b0;
        @(negedge clk);
        check({tag, "_done_clear"}, done, 0);
    endtask

    initial begin
        logic [7:0] lit[6];
        logic [8*NB-1:0] pl;
        int base;
        int s0;
        int p0;
        int cyc;
        lit = '{8'hAA, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        clear_plan();

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {start, stop, i2c_en, busy, done, error}, 0);
        check("reset_tx_data", tx_data, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Plain packet, literal byte sequence
        base = cap_log.size(); s0 = cap_starts; p0 = cap_stops;
        run_packet(40'h0504030201, 1'b0, 1'b0, "basic");
        check("basic_nbytes", cap_log.size() - base, 6);
        for (int k = 0; k < 6; k++) check($sformatf("basic_byte%0d", k), cap_log[base+k], lit[k]);
        check("basic_starts", cap_starts - s0, 1);
        check("basic_stops", cap_stops - p0, 1);

        // NACK on payload byte index 2, ACK on re-send
        clear_plan(); plan_nack[0] = 3;
        s0 = cap_starts;
        run_packet(40'h0504030201, 1'b0, 1'b0, "nack_b2");
        check("nack_b2_starts", cap_starts - s0, RETRY_EN ? 2 : 1);
        check("nack_b2_error", error, 0);

        // Persistent address NACK
        clear_plan(); for (int i = 0; i < 8; i++) plan_nack[i] = 0;
        s0 = cap_starts; p0 = cap_stops;
        run_packet(40'h1122334455, 1'b0, 1'b0, "addr_nack");
        check("addr_nack_starts", cap_starts - s0, RETRY_EN ? 3 : 1);
        check("addr_nack_stops", cap_stops - p0, RETRY_EN ? 3 : 1);

        // Abort at the end of byte 1 (slot 2)
        clear_plan(); plan_nack[0] = -1; abort_slot = 2;
        base = cap_log.size(); s0 = cap_starts;
        run_packet(40'h0504030201, 1'b0, 1'b0, "abort");
        check("abort_nbytes", cap_log.size() - base, 3);
        check("abort_last_byte", cap_log[cap_log.size()-1], 8'h02);
        check("abort_starts", cap_starts - s0, 1);

        // Payload changes after snapshot; trigger held through DONE
        clear_plan();
        run_packet(40'hA1B2C3D4E5, 1'b1, 1'b1, "snapshot");

        // Reset asserted in DATA_REQ
        clear_plan(); sb_en = 1'b0;
        @(negedge clk);
        payload = 40'h9988776655;
        send_trigger = 1'b1;
        cyc = 0;
        while (!(i2c_en && !start && !stop) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_data_req", i2c_en && !start && !stop, 1);
        reset = 1'b0;
        #1;
        check("midreset_outputs", {start, stop, i2c_en, busy, done, error}, 0);
        check("midreset_tx_data", tx_data, 0);
        send_trigger = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb_en = 1'b1;
        run_packet(40'h0102030405, 1'b0, 1'b0, "after_reset");

        // Randomized packets
        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < NB; b++) pl[8*b +: 8] = 8'($urandom_range(0, 255));
            for (int i = 0; i < 8; i++)
                plan_nack[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, NB)) : -1;
            abort_slot = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NB)) : -1;
            run_packet(pl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
